pipelined_cla_adder: RTL and testbench
======================================

Name: pipelined_cla_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. It replaces the fixed-width combinational final adder of the MAC datapath. The operands are split into BLK_W-bit lookahead blocks, one block per pipeline stage, with the carry registered between stages. It adds carry-in, carry-out, subtract mode, overflow and a valid/ready stream interface with backpressure.

Parameters:
A_W, 33, width of operand A; zero- or sign-extended to S_W.
B_W, 34, width of operand B; zero- or sign-extended to S_W.
S_W, 34, sum width; A_W <= S_W and B_W <= S_W, enforced by elaboration-time check.
BLK_W, 8, lookahead block width; NUM_BLK = ceil(S_W/BLK_W) is derived, and the last block may be partial.
SIGNED, 0, 1 selects sign extension and two's-complement overflow.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts a beat this cycle
in_a  in  A_W  operand A
in_b  in  B_W  operand B
in_cin  in  1  carry-in (add) / borrow-in (sub)
in_sub  in  1  1 = subtract
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_sum  out  S_W  result
out_cout  out  1  carry out of bit S_W-1
out_ovf  out  1  overflow flag

Behaviour:
- Single clock domain.
- Reset is synchronous and active-low: rst_n sampled low at a clk edge clears all stage valid bits and all data/carry registers to 0.
- Outputs after reset: out_valid=0, out_sum=0, out_cout=0, out_ovf=0; in_ready=1.
- Transfer rules: an input beat is accepted when in_valid && in_ready; a result is consumed when out_valid && out_ready.
- Operand prep at accept:
  - A and B are extended to S_W bits (sign-extended if SIGNED=1, else zero-extended).
  - If in_sub=1: B is inverted and the stage-0 carry = ~in_cin, giving A - B - in_cin.
  - If in_sub=0: the stage-0 carry = in_cin.
- Stage k (k = 0..NUM_BLK-1):
  - Computes block k with 4-bit-group lookahead (G/P per bit, group G/P, block carry-out).
  - Input is the registered carry from stage k-1.
  - Higher operand blocks are skewed forward in registers; completed lower sum blocks are delayed forward.
- Latency: a result appears on out_* exactly NUM_BLK cycles after acceptance when never stalled (5 cycles at defaults).
- Throughput: one result per cycle.
- Stall: advance = !(out_valid && !out_ready).
  - in_ready = advance.
  - When advance=0, every stage register holds.
  - Bubbles are not collapsed; the pipeline moves as one shift register.
- Holding: out_sum, out_cout and out_ovf stay stable while out_valid && !out_ready.
- Flags:
  - out_cout = carry out of the top bit.
  - SIGNED=0: out_ovf = out_cout ^ in_sub of that beat (unsigned overflow or borrow).
  - SIGNED=1: out_ovf = carry into bit S_W-1 XOR carry out of bit S_W-1.
  - in_sub is piped along with its beat.
- Partial last block: bits above S_W-1 are forced to 0 and are never visible.
- Simultaneous accept and consume in one cycle is legal and yields full throughput.
- Reset mid-stream: all in-flight beats are discarded; no stale result ever emerges.
- in_valid is ignored while in_ready=0. Sources must hold their beat, per the standard valid/ready rule.

Decomposition:
- Shared package mac_pkg:
  - function ceil_div for NUM_BLK
  - constant LA_GRP=4 (lookahead group size)
  - default width constants for the MAC final adder (A_W=33, B_W=34, S_W=34)
- One combinational sub-module, cla_block:
  - Parameter: BLK_W.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, c_msb (carry into the block MSB, used for signed overflow).
  - Instantiated once per stage via generate.
- The top holds the skew/deskew registers, valid bits and stall logic.

Test Plan:
- Defaults. A=1, B=34'h3_FFFF_FFFF, cin=0, add -> 5 cycles later: out_sum=0, out_cout=1, out_ovf=1.
- Full carry ripple across all blocks. A=33'h1_FFFF_FFFF, B=1 -> out_sum=34'h2_0000_0000, out_cout=0, out_ovf=0.
- Subtract. A=5, B=7, in_sub=1, cin=0 -> out_sum=34'h3_FFFF_FFFE, out_cout=0, out_ovf=1. With cin=1 -> out_sum=34'h3_FFFF_FFFD.
- SIGNED=1. A=33'h0_FFFF_FFFF, B=34'h0_0000_0001 -> out_sum=34'h1_0000_0000, out_ovf=0. Then A=B=33'h0_FFFF_FFFF (S_W=33 build) -> out_ovf=1.
- Stream 20 random beats with out_ready=1 -> out_valid on 20 consecutive cycles, in order, each matching the reference model. Then drop out_ready for 3 cycles with the pipeline full -> in_ready=0, out_sum stable, no loss or duplication after release.
- Assert rst_n=0 for one cycle with 3 beats in flight -> out_valid=0 from the next cycle and in_ready=1. No results emerge in the following 10 cycles with in_valid=0.

Source files
------------

// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants and helpers for the MAC final-adder datapath.
// Pure declarations: no logic, no latency, no flow control.
package mac_pkg;
  localparam int LA_GRP  = 4;
  localparam int MAC_A_W = 33;
  localparam int MAC_B_W = 34;
  localparam int MAC_S_W = 34;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction
endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result stream bundle for the pipelined adder.
// Valid/ready in both directions; the master is the source of operands and sink of results.
interface pipelined_cla_adder_if #(
  parameter int A_W = 33,
  parameter int B_W = 34,
  parameter int S_W = 34
) ();
  logic           in_valid;
  logic           in_ready;
  logic [A_W-1:0] in_a;
  logic [B_W-1:0] in_b;
  logic           in_cin;
  logic           in_sub;
  logic           out_valid;
  logic           out_ready;
  logic [S_W-1:0] out_sum;
  logic           out_cout;
  logic           out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/pipelined_cla_adder_cla_block.sv
// One lookahead block: per-bit G/P, 4-bit group G/P, group-level carry chain.
// Purely combinational (0 cycles); no flow control.
module cla_block
  import mac_pkg::*;
#(
  parameter int BLK_W = 8
) (
  input  logic [BLK_W-1:0] a,
  input  logic [BLK_W-1:0] b,
  input  logic             cin,
  output logic [BLK_W-1:0] sum,
  output logic             cout,
  output logic             c_msb
);
  localparam int NGRP = ceil_div(BLK_W, LA_GRP);

  logic [BLK_W-1:0] g;
  logic [BLK_W-1:0] p;
  logic [BLK_W-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    logic gg;
    logic pp;
    logic cg;
    logic cc;
    int   idx;
    c    = '0;
    cg   = cin;
    gg   = 1'b0;
    pp   = 1'b1;
    cc   = 1'b0;
    idx  = 0;
    for (int j = 0; j < NGRP; j++) begin
      gg = 1'b0;
      pp = 1'b1;
      for (int k = 0; k < LA_GRP; k++) begin
        idx = j * LA_GRP + k;
        if (idx < BLK_W) begin
          gg = g[idx] | (p[idx] & gg);
          pp = pp & p[idx];
        end
      end
      // Bit carries inside the group start from the lookahead group carry.
      cc = cg;
      for (int k = 0; k < LA_GRP; k++) begin
        idx = j * LA_GRP + k;
        if (idx < BLK_W) begin
          c[idx] = cc;
          cc     = g[idx] | (p[idx] & cc);
        end
      end
      cg = gg | (pp & cg);
    end
    cout = cg;
  end

  assign sum   = p ^ c;
  assign c_msb = c[BLK_W-1];
endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor, one BLK_W block per stage with registered inter-block carry.
// Latency NUM_BLK cycles, one beat/cycle; whole pipe freezes while a result is held by out_ready=0.
module pipelined_cla_adder
  import mac_pkg::*;
#(
  parameter int A_W    = MAC_A_W,
  parameter int B_W    = MAC_B_W,
  parameter int S_W    = MAC_S_W,
  parameter int BLK_W  = 8,
  parameter int SIGNED = 0
) (
  input logic                clk,
  input logic                rst_n,
  pipelined_cla_adder_if.slave bus
);
  localparam int NUM_BLK = ceil_div(S_W, BLK_W);
  localparam int P_W     = NUM_BLK * BLK_W;
  localparam int LAST    = NUM_BLK - 1;

  if (A_W > S_W || B_W > S_W) begin : g_width_check
    $error("pipelined_cla_adder: operand wider than sum");
  end

  logic [P_W-1:0]     a_q   [NUM_BLK];
  logic [P_W-1:0]     b_q   [NUM_BLK];
  logic [P_W-1:0]     s_q   [NUM_BLK];
  logic [P_W-1:0]     s_nxt [NUM_BLK];
  logic [NUM_BLK-1:0] c_q;
  logic [NUM_BLK-1:0] sub_q;
  logic [NUM_BLK-1:0] vld_q;

  logic [BLK_W-1:0]   blk_sum [NUM_BLK];
  logic [NUM_BLK-1:0] blk_cout;
  logic [NUM_BLK-1:0] blk_cmsb;

  logic [S_W-1:0] a_ext;
  logic [S_W-1:0] b_ext;
  logic [P_W-1:0] a_prep;
  logic [P_W-1:0] b_prep;
  logic           cin_prep;

  logic           out_vld_q;
  logic [S_W-1:0] out_sum_q;
  logic           out_cout_q;
  logic           out_ovf_q;

  logic advance;
  logic top_cout;
  logic top_cin;
  logic top_ovf;

  assign advance      = !(out_vld_q && !bus.out_ready);
  assign bus.in_ready = advance;
  assign bus.out_valid = out_vld_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.out_ovf   = out_ovf_q;

  always_comb begin
    if (SIGNED != 0) begin
      a_ext = S_W'($signed(bus.in_a));
      b_ext = S_W'($signed(bus.in_b));
    end else begin
      a_ext = S_W'(bus.in_a);
      b_ext = S_W'(bus.in_b);
    end
  end

  // Padding above S_W-1 stays zero so the partial top block never leaks bits.
  assign a_prep   = P_W'(a_ext);
  assign b_prep   = P_W'(b_ext ^ {S_W{bus.in_sub}});
  assign cin_prep = bus.in_cin ^ bus.in_sub;

  for (genvar k = 0; k < NUM_BLK; k++) begin : g_stage
    cla_block #(.BLK_W(BLK_W)) u_blk (
      .a     (a_q[k][k*BLK_W +: BLK_W]),
      .b     (b_q[k][k*BLK_W +: BLK_W]),
      .cin   (c_q[k]),
      .sum   (blk_sum[k]),
      .cout  (blk_cout[k]),
      .c_msb (blk_cmsb[k])
    );
  end

  always_comb begin
    for (int k = 0; k < NUM_BLK; k++) begin
      s_nxt[k]                    = s_q[k];
      s_nxt[k][k*BLK_W +: BLK_W] = blk_sum[k];
    end
  end

  // With a partial top block, carry out of bit S_W-1 lands in the first padding sum bit.
  if (P_W == S_W) begin : g_full_top
    assign top_cout = blk_cout[LAST];
    assign top_cin  = blk_cmsb[LAST];
  end else begin : g_part_top
    assign top_cout = s_nxt[LAST][S_W];
    assign top_cin  = s_nxt[LAST][S_W-1] ^ a_q[LAST][S_W-1] ^ b_q[LAST][S_W-1];
  end

  assign top_ovf = (SIGNED != 0) ? (top_cin ^ top_cout) : (top_cout ^ sub_q[LAST]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_BLK; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q        <= '0;
      sub_q      <= '0;
      vld_q      <= '0;
      out_vld_q  <= 1'b0;
      out_sum_q  <= '0;
      out_cout_q <= 1'b0;
      out_ovf_q  <= 1'b0;
    end else if (advance) begin
      vld_q[0] <= bus.in_valid;
      if (bus.in_valid) begin
        a_q[0]   <= a_prep;
        b_q[0]   <= b_prep;
        s_q[0]   <= '0;
        c_q[0]   <= cin_prep;
        sub_q[0] <= bus.in_sub;
      end
      for (int k = 1; k < NUM_BLK; k++) begin
        vld_q[k] <= vld_q[k-1];
        a_q[k]   <= a_q[k-1];
        b_q[k]   <= b_q[k-1];
        s_q[k]   <= s_nxt[k-1];
        c_q[k]   <= blk_cout[k-1];
        sub_q[k] <= sub_q[k-1];
      end
      out_vld_q  <= vld_q[LAST];
      out_sum_q  <= s_nxt[LAST][S_W-1:0];
      out_cout_q <= top_cout;
      out_ovf_q  <= top_ovf;
    end
  end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder: unsigned default build plus two signed builds.
module tb_pipelined_cla_adder;
  import mac_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipelined_cla_adder_if #(.A_W(33), .B_W(34), .S_W(34)) u_if ();
  pipelined_cla_adder_if #(.A_W(33), .B_W(34), .S_W(34)) s_if ();
  pipelined_cla_adder_if #(.A_W(33), .B_W(33), .S_W(33)) t_if ();

  pipelined_cla_adder #(.A_W(33), .B_W(34), .S_W(34), .BLK_W(8), .SIGNED(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(u_if.slave));
  pipelined_cla_adder #(.A_W(33), .B_W(34), .S_W(34), .BLK_W(8), .SIGNED(1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .bus(s_if.slave));
  pipelined_cla_adder #(.A_W(33), .B_W(33), .S_W(33), .BLK_W(8), .SIGNED(1)) u_s33 (
    .clk(clk), .rst_n(rst_n), .bus(t_if.slave));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent arithmetic reference: returns {ovf, cout, sum}.
  function automatic logic [35:0] ref_model(input logic [32:0] a, input logic [33:0] b,
                                            input logic ci, input logic sb);
    logic [34:0] r;
    if (!sb) begin
      r = {2'b00, a} + {1'b0, b} + 35'(ci);
      return {r[34], r[34], r[33:0]};
    end
    r = {2'b00, a} - {1'b0, b} - 35'(ci);
    return {r[34], ~r[34], r[33:0]};
  endfunction

  task automatic run_one(input string tag, input logic [32:0] a, input logic [33:0] b,
                         input logic ci, input logic sb, input logic [33:0] esum,
                         input logic ecout, input logic eovf);
    int lat;
    u_if.in_a = a; u_if.in_b = b; u_if.in_cin = ci; u_if.in_sub = sb;
    u_if.in_valid = 1'b1;
    tick();
    u_if.in_valid = 1'b0;
    lat = 0;
    while (!u_if.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'd5);
    check({tag, "_sum"}, 64'(u_if.out_sum), 64'(esum));
    check({tag, "_cout"}, 64'(u_if.out_cout), 64'(ecout));
    check({tag, "_ovf"}, 64'(u_if.out_ovf), 64'(eovf));
    tick();
  endtask

  task automatic run_sgn(input string tag,
                         input logic [32:0] a1, input logic [33:0] b1, input logic [33:0] s1,
                         input logic c1, input logic o1,
                         input logic [32:0] a2, input logic [32:0] b2, input logic [32:0] s2,
                         input logic c2, input logic o2);
    int lat;
    s_if.in_a = a1; s_if.in_b = b1; s_if.in_cin = 1'b0; s_if.in_sub = 1'b0;
    t_if.in_a = a2; t_if.in_b = b2; t_if.in_cin = 1'b0; t_if.in_sub = 1'b0;
    s_if.in_valid = 1'b1; t_if.in_valid = 1'b1;
    tick();
    s_if.in_valid = 1'b0; t_if.in_valid = 1'b0;
    lat = 0;
    while (!s_if.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_s34_lat"}, 64'(lat), 64'd5);
    check({tag, "_s34_sum"}, 64'(s_if.out_sum), 64'(s1));
    check({tag, "_s34_cout"}, 64'(s_if.out_cout), 64'(c1));
    check({tag, "_s34_ovf"}, 64'(s_if.out_ovf), 64'(o1));
    check({tag, "_s33_vld"}, 64'(t_if.out_valid), 64'd1);
    check({tag, "_s33_sum"}, 64'(t_if.out_sum), 64'(s2));
    check({tag, "_s33_cout"}, 64'(t_if.out_cout), 64'(c2));
    check({tag, "_s33_ovf"}, 64'(t_if.out_ovf), 64'(o2));
    tick();
  endtask

  // Continuous random stream on the unsigned DUT, with an optional out_ready drop.
  task automatic run_stream(input string tag, input int nbeats, input int stall_at,
                            input int stall_len);
    logic [35:0] expq[$];
    logic [35:0] e;
    logic [32:0] a;
    logic [33:0] b;
    logic        ci, sb, acc;
    logic [33:0] held;
    int sent, got, cyc, first, last;
    sent = 0; got = 0; cyc = 0; first = -1; last = -1; acc = 1'b0; held = '0;
    while (got < nbeats && cyc < 300) begin
      if (!u_if.in_valid || acc) begin
        if (sent < nbeats) begin
          a  = 33'({$urandom(), $urandom()});
          b  = 34'({$urandom(), $urandom()});
          ci = 1'($urandom_range(0, 1));
          sb = 1'($urandom_range(0, 1));
          u_if.in_a = a; u_if.in_b = b; u_if.in_cin = ci; u_if.in_sub = sb;
          u_if.in_valid = 1'b1;
          expq.push_back(ref_model(a, b, ci, sb));
          sent++;
        end else begin
          u_if.in_valid = 1'b0;
        end
      end
      u_if.out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      #1;
      if (!u_if.out_ready) begin
        check({tag, "_stall_rdy"}, 64'(u_if.in_ready), 64'd0);
        if (cyc > stall_at) check({tag, "_stall_hold"}, 64'(u_if.out_sum), 64'(held));
        held = u_if.out_sum;
      end else if (stall_len > 0 && cyc == stall_at + stall_len) begin
        check({tag, "_release_hold"}, 64'(u_if.out_sum), 64'(held));
      end
      if (u_if.out_valid && u_if.out_ready) begin
        if (expq.size() == 0) begin
          check({tag, "_extra_result"}, 64'd1, 64'd0);
        end else begin
          e = expq.pop_front();
          check({tag, "_res"}, 64'({u_if.out_ovf, u_if.out_cout, u_if.out_sum}), 64'(e));
        end
        got++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      acc = u_if.in_valid && u_if.in_ready;
      tick();
      cyc++;
    end
    u_if.in_valid = 1'b0;
    u_if.out_ready = 1'b1;
    check({tag, "_count"}, 64'(got), 64'(nbeats));
    check({tag, "_left"}, 64'(expq.size()), 64'd0);
    if (stall_len == 0) check({tag, "_consec"}, 64'(last - first + 1), 64'(nbeats));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_n = 1'b0;
    u_if.in_valid = 1'b0; u_if.in_a = '0; u_if.in_b = '0; u_if.in_cin = 1'b0;
    u_if.in_sub = 1'b0; u_if.out_ready = 1'b1;
    s_if.in_valid = 1'b0; s_if.in_a = '0; s_if.in_b = '0; s_if.in_cin = 1'b0;
    s_if.in_sub = 1'b0; s_if.out_ready = 1'b1;
    t_if.in_valid = 1'b0; t_if.in_a = '0; t_if.in_b = '0; t_if.in_cin = 1'b0;
    t_if.in_sub = 1'b0; t_if.out_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;

    check("rst_out_valid", 64'(u_if.out_valid), 64'd0);
    check("rst_out_sum", 64'(u_if.out_sum), 64'd0);
    check("rst_out_cout", 64'(u_if.out_cout), 64'd0);
    check("rst_out_ovf", 64'(u_if.out_ovf), 64'd0);
    check("rst_in_ready", 64'(u_if.in_ready), 64'd1);

    run_one("wrap", 33'h0_0000_0001, 34'h3_FFFF_FFFF, 1'b0, 1'b0, 34'h0, 1'b1, 1'b1);
    run_one("ripple", 33'h1_FFFF_FFFF, 34'h0_0000_0001, 1'b0, 1'b0, 34'h2_0000_0000, 1'b0, 1'b0);
    run_one("sub_5_7", 33'd5, 34'd7, 1'b0, 1'b1, 34'h3_FFFF_FFFE, 1'b0, 1'b1);
    run_one("sub_5_7_b", 33'd5, 34'd7, 1'b1, 1'b1, 34'h3_FFFF_FFFD, 1'b0, 1'b1);
    run_one("sub_7_5", 33'd7, 34'd5, 1'b0, 1'b1, 34'h0_0000_0002, 1'b1, 1'b0);
    run_one("cin_wrap", 33'd0, 34'h3_FFFF_FFFF, 1'b1, 1'b0, 34'h0, 1'b1, 1'b1);

    run_sgn("sgn_a", 33'h0_FFFF_FFFF, 34'h0_0000_0001, 34'h1_0000_0000, 1'b0, 1'b0,
                     33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 33'h1_FFFF_FFFE, 1'b0, 1'b1);
    run_sgn("sgn_b", 33'h1_0000_0000, 34'h2_0000_0000, 34'h1_0000_0000, 1'b1, 1'b1,
                     33'h1_FFFF_FFFF, 33'h0_0000_0001, 33'h0_0000_0000, 1'b1, 1'b0);

    run_stream("stream", 20, 1000, 0);
    run_stream("stall", 12, 8, 3);

    // Three beats in flight, then a one-cycle reset must flush them all.
    for (int i = 0; i < 3; i++) begin
      u_if.in_a = 33'(i + 1); u_if.in_b = 34'(i + 10); u_if.in_cin = 1'b0; u_if.in_sub = 1'b0;
      u_if.in_valid = 1'b1;
      tick();
    end
    u_if.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("flush_out_valid", 64'(u_if.out_valid), 64'd0);
    check("flush_in_ready", 64'(u_if.in_ready), 64'd1);
    check("flush_out_sum", 64'(u_if.out_sum), 64'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (u_if.out_valid) seen++;
    end
    check("flush_no_stale", 64'(seen), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
